// File: rtl/pipe_pkg.sv
// Shared pipeline constants: ID control-bundle bit map, RegDst codes.
// Imported by id_ex_stage and hazard_detect.
package pipe_pkg;

    localparam int CTRL_W = 24;

    // Control bundle, MSB first:
    // {ImmSrc, PCSrc[1:0], BranchOp[2:0], RegDst[1:0], ALUSrc[2:0],
    //  ALUOp[3:0], ExtOp, RegWrite, MemWrite, MemRead, MemToReg[1:0],
    //  jump_hazard, is_lb, pad}
    // The named fields fill bits 23..1; bit 0 is the reserved pad.
    localparam int IMMSRC_BIT   = 23;
    localparam int PCSRC_LSB    = 21;
    localparam int BRANCHOP_LSB = 18;
    localparam int REGDST_LSB   = 16;
    localparam int ALUSRC_LSB   = 13;
    localparam int ALUOP_LSB    = 9;
    localparam int EXTOP_BIT    = 8;
    localparam int REGWRITE_BIT = 7;
    localparam int MEMWRITE_BIT = 6;
    localparam int MEMREAD_BIT  = 5;
    localparam int MEMTOREG_LSB = 3;
    localparam int JUMPHAZ_BIT  = 2;
    localparam int ISLB_BIT     = 1;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_RA   = 2'b10,
        REGDST_NONE = 2'b11
    } regdst_e;

    localparam logic [4:0] RA_IDX = 5'd31;

    function automatic regdst_e reg_dst_of(
        input logic [CTRL_W-1:0] ctrl
    );
        return regdst_e'(ctrl[REGDST_LSB +: 2]);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard, PC/IF-ID stall and IF-ID flush generation.
// In: reset, EX MemRead/dest reg, ID rs/rt/RegDst/MemWrite/jump, branch.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       reset,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_wr_reg_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic [1:0] id_reg_dst_i,
    input  logic       id_mem_write_i,
    input  logic       id_jump_hazard_i,
    input  logic       branch_taken_i,
    output logic       stall_o,
    output logic       flush_ifid_o
);

    logic rt_is_src;
    logic load_use;
    logic stall;

    always_comb begin
        // rt is read by R-type (rd destination) and by stores
        rt_is_src = (regdst_e'(id_reg_dst_i) == REGDST_RD)
                  | id_mem_write_i;
        load_use  = ex_mem_read_i
                  & (ex_wr_reg_i != 5'd0)
                  & ((ex_wr_reg_i == id_rs_i)
                  | ((ex_wr_reg_i == id_rt_i) & rt_is_src));
        // a taken branch squashes the consumer, so no stall needed
        stall        = ~reset & load_use & ~branch_taken_i;
        stall_o      = stall;
        flush_ifid_o = ~reset
                     & (branch_taken_i | (id_jump_hazard_i & ~stall));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble and branch squash.
// Ports: clk, reset (async high), id_* in, ex_* out, stall_o,
// flush_ifid_o, bubble_cnt_o. Macro ID_EX_PERF_CNT_EN adds the
// bubble counter; otherwise bubble_cnt_o is tied to zero.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic [4:0]        id_rd_i,
    input  logic [4:0]        id_shamt_i,
    input  logic              branch_taken_i,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_shamt_o,
    output logic [4:0]        ex_wr_reg_o,
    output logic              stall_o,
    output logic              flush_ifid_o,
    output logic [31:0]       bubble_cnt_o
);

    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [DATA_W-1:0] ex_pc4_q, ex_pc4_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [4:0]        ex_shamt_q, ex_shamt_d;
    logic              bubble;

    hazard_detect u_hazard (
        .reset            (reset),
        .ex_mem_read_i    (ex_ctrl_q[MEMREAD_BIT]),
        .ex_wr_reg_i      (ex_wr_reg_o),
        .id_rs_i          (id_rs_i),
        .id_rt_i          (id_rt_i),
        .id_reg_dst_i     (id_ctrl_i[REGDST_LSB +: 2]),
        .id_mem_write_i   (id_ctrl_i[MEMWRITE_BIT]),
        .id_jump_hazard_i (id_ctrl_i[JUMPHAZ_BIT]),
        .branch_taken_i   (branch_taken_i),
        .stall_o          (stall_o),
        .flush_ifid_o     (flush_ifid_o)
    );

    always_comb begin
        bubble       = branch_taken_i | stall_o;
        // bubble zeroes control only; operand fields still flow
        ex_ctrl_d    = bubble ? '0 : id_ctrl_i;
        ex_rs_data_d = id_rs_data_i;
        ex_rt_data_d = id_rt_data_i;
        ex_imm_d     = id_imm_i;
        ex_pc4_d     = id_pc4_i;
        ex_rs_d      = id_rs_i;
        ex_rt_d      = id_rt_i;
        ex_rd_d      = id_rd_i;
        ex_shamt_d   = id_shamt_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl_q    <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_pc4_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_shamt_q   <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc4_q     <= ex_pc4_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_shamt_q   <= ex_shamt_d;
        end
    end

    always_comb begin
        ex_wr_reg_o = ex_rt_q;
        unique case (reg_dst_of(ex_ctrl_q))
            REGDST_RT:   ex_wr_reg_o = ex_rt_q;
            REGDST_RD:   ex_wr_reg_o = ex_rd_q;
            REGDST_RA:   ex_wr_reg_o = RA_IDX;
            REGDST_NONE: ex_wr_reg_o = 5'd0;
        endcase
    end

    assign ex_ctrl_o    = ex_ctrl_q;
    assign ex_rs_data_o = ex_rs_data_q;
    assign ex_rt_data_o = ex_rt_data_q;
    assign ex_imm_o     = ex_imm_q;
    assign ex_pc4_o     = ex_pc4_q;
    assign ex_rs_o      = ex_rs_q;
    assign ex_rt_o      = ex_rt_q;
    assign ex_shamt_o   = ex_shamt_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q + {31'd0, bubble};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign bubble_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table vectors, hand sequences, random vs model.
// Honors ID_EX_PERF_CNT_EN for the bubble counter expectations.
module tb_id_ex_stage;

    localparam int DW = 32;

    // control bundle bit map, written out independently of the RTL
    localparam int B_PCSRC  = 21;
    localparam int B_BROP   = 18;
    localparam int B_REGDST = 16;
    localparam int B_ALUSRC = 13;
    localparam int B_ALUOP  = 9;
    localparam int B_EXTOP  = 8;
    localparam int B_REGWR  = 7;
    localparam int B_MEMWR  = 6;
    localparam int B_MEMRD  = 5;
    localparam int B_M2R    = 3;
    localparam int B_JMP    = 2;
    localparam int B_LB     = 1;

    localparam logic [23:0] C_LW = (24'h1 << B_MEMRD) | (24'h1 << B_REGWR)
                                 | (24'h1 << B_M2R) | (24'h1 << B_ALUSRC);
    localparam logic [23:0] C_LB = C_LW | (24'h1 << B_LB);
    localparam logic [23:0] C_ADD = (24'h1 << B_REGWR) | (24'h1 << B_REGDST)
                                  | (24'h2 << B_ALUOP);
    localparam logic [23:0] C_ADDI = (24'h1 << B_REGWR) | (24'h1 << B_ALUSRC)
                                   | (24'h1 << B_EXTOP);
    localparam logic [23:0] C_SW = (24'h1 << B_MEMWR) | (24'h1 << B_ALUSRC)
                                 | (24'h3 << B_REGDST);
    localparam logic [23:0] C_JAL = (24'h1 << B_JMP) | (24'h2 << B_REGDST)
                                  | (24'h2 << B_M2R) | (24'h1 << B_REGWR)
                                  | (24'h2 << B_PCSRC);
    localparam logic [23:0] C_BEQ = (24'h1 << B_BROP) | (24'h1 << B_PCSRC)
                                  | (24'h3 << B_REGDST);

    logic          clk = 1'b0;
    logic          reset;
    logic [23:0]   id_ctrl_i;
    logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i, id_pc4_i;
    logic [4:0]    id_rs_i, id_rt_i, id_rd_i, id_shamt_i;
    logic          branch_taken_i;
    logic [23:0]   ex_ctrl_o;
    logic [DW-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o;
    logic [4:0]    ex_rs_o, ex_rt_o, ex_shamt_o, ex_wr_reg_o;
    logic          stall_o, flush_ifid_o;
    logic [31:0]   bubble_cnt_o;

    id_ex_stage #(.DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_ctrl_i      (id_ctrl_i),
        .id_rs_data_i   (id_rs_data_i),
        .id_rt_data_i   (id_rt_data_i),
        .id_imm_i       (id_imm_i),
        .id_pc4_i       (id_pc4_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_rd_i        (id_rd_i),
        .id_shamt_i     (id_shamt_i),
        .branch_taken_i (branch_taken_i),
        .ex_ctrl_o      (ex_ctrl_o),
        .ex_rs_data_o   (ex_rs_data_o),
        .ex_rt_data_o   (ex_rt_data_o),
        .ex_imm_o       (ex_imm_o),
        .ex_pc4_o       (ex_pc4_o),
        .ex_rs_o        (ex_rs_o),
        .ex_rt_o        (ex_rt_o),
        .ex_shamt_o     (ex_shamt_o),
        .ex_wr_reg_o    (ex_wr_reg_o),
        .stall_o        (stall_o),
        .flush_ifid_o   (flush_ifid_o),
        .bubble_cnt_o   (bubble_cnt_o)
    );

    always #5 clk = ~clk;

    // what the EX stage holds, as the model sees it
    typedef struct {
        logic [23:0]   ctrl;
        logic [DW-1:0] rs_data, rt_data, imm, pc4;
        logic [4:0]    rs, rt, rd, shamt;
    } ex_t;

    typedef struct {
        logic [23:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic        bt;
        logic        exp_stall, exp_flush;
        logic [23:0] exp_ctrl;
        logic [4:0]  exp_wr;
    } vec_t;

    ex_t         m_ex;
    logic [31:0] m_cnt;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        tbl[16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [4:0] m_dest(input ex_t e);
        logic [1:0] rd_sel;
        rd_sel = e.ctrl[B_REGDST +: 2];
        if (rd_sel == 2'd0) return e.rt;
        if (rd_sel == 2'd1) return e.rd;
        if (rd_sel == 2'd2) return 5'd31;
        return 5'd0;
    endfunction

    // a load in EX blocks an ID consumer of its destination
    function automatic logic m_stall();
        logic [4:0] d;
        logic       uses_rt;
        d = m_dest(m_ex);
        uses_rt = (id_ctrl_i[B_REGDST +: 2] == 2'd1) || id_ctrl_i[B_MEMWR];
        if (branch_taken_i) return 1'b0;
        if (!m_ex.ctrl[B_MEMRD] || d == 5'd0) return 1'b0;
        return (d == id_rs_i) || (d == id_rt_i && uses_rt);
    endfunction

    task automatic drive(input logic [23:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic bt);
        id_ctrl_i      = c;
        id_rs_i        = rs;
        id_rt_i        = rt;
        id_rd_i        = rd;
        id_shamt_i     = 5'($urandom);
        id_rs_data_i   = $urandom;
        id_rt_data_i   = $urandom;
        id_imm_i       = $urandom;
        id_pc4_i       = $urandom;
        branch_taken_i = bt;
    endtask

    // called 1 time unit after inputs settle; returns at next negedge
    task automatic cycle_model();
        logic es, ef, bub;
        ex_t  nx;
        es  = m_stall();
        ef  = branch_taken_i || (id_ctrl_i[B_JMP] && !es);
        bub = branch_taken_i || es;
        chk("stall", stall_o, es);
        chk("flush", flush_ifid_o, ef);
        nx.ctrl    = bub ? 24'h0 : id_ctrl_i;
        nx.rs_data = id_rs_data_i;
        nx.rt_data = id_rt_data_i;
        nx.imm     = id_imm_i;
        nx.pc4     = id_pc4_i;
        nx.rs      = id_rs_i;
        nx.rt      = id_rt_i;
        nx.rd      = id_rd_i;
        nx.shamt   = id_shamt_i;
        @(posedge clk);
        m_ex = nx;
`ifdef ID_EX_PERF_CNT_EN
        if (bub) m_cnt = m_cnt + 32'd1;
`endif
        #1;
        chk("ex_ctrl", ex_ctrl_o, m_ex.ctrl);
        chk("ex_rs_data", ex_rs_data_o, m_ex.rs_data);
        chk("ex_rt_data", ex_rt_data_o, m_ex.rt_data);
        chk("ex_imm", ex_imm_o, m_ex.imm);
        chk("ex_pc4", ex_pc4_o, m_ex.pc4);
        chk("ex_rs", ex_rs_o, m_ex.rs);
        chk("ex_rt", ex_rt_o, m_ex.rt);
        chk("ex_shamt", ex_shamt_o, m_ex.shamt);
        chk("ex_wr_reg", ex_wr_reg_o, m_dest(m_ex));
        chk("bubble_cnt", bubble_cnt_o, m_cnt);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [23:0] c, input int rs,
                                input int rt, input int rd, input logic bt,
                                input logic st, input logic fl,
                                input logic [23:0] ec, input int wr);
        vec_t v;
        v.ctrl = c; v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
        v.bt = bt; v.exp_stall = st; v.exp_flush = fl;
        v.exp_ctrl = ec; v.exp_wr = 5'(wr);
        return v;
    endfunction

    initial begin
        logic [23:0] ops[8];
        ops = '{C_LW, C_LB, C_ADD, C_ADDI, C_SW, C_JAL, C_BEQ, 24'h0};

        tbl[0]  = mk(C_LW,   1, 8, 0, 0, 0, 0, C_LW,   8);
        tbl[1]  = mk(C_ADD,  8, 2, 3, 0, 1, 0, 24'h0,  2);
        tbl[2]  = mk(C_ADD,  8, 2, 3, 0, 0, 0, C_ADD,  3);
        tbl[3]  = mk(C_LW,   1, 0, 0, 0, 0, 0, C_LW,   0);
        tbl[4]  = mk(C_ADD,  0, 0, 4, 0, 0, 0, C_ADD,  4);
        tbl[5]  = mk(C_LW,   4, 9, 0, 0, 0, 0, C_LW,   9);
        tbl[6]  = mk(C_ADD,  1, 9, 5, 1, 0, 1, 24'h0,  9);
        tbl[7]  = mk(C_LW,   1, 10, 0, 0, 0, 0, C_LW,  10);
        tbl[8]  = mk(C_ADDI, 2, 10, 0, 0, 0, 0, C_ADDI, 10);
        tbl[9]  = mk(C_LW,   2, 11, 0, 0, 0, 0, C_LW,  11);
        tbl[10] = mk(C_SW,   2, 11, 0, 0, 1, 0, 24'h0, 11);
        tbl[11] = mk(C_SW,   2, 11, 0, 0, 0, 0, C_SW,   0);
        tbl[12] = mk(C_JAL,  0, 0, 0, 0, 0, 1, C_JAL,  31);
        tbl[13] = mk(C_LB,   0, 12, 0, 0, 0, 0, C_LB,  12);
        tbl[14] = mk(C_JAL, 12, 0, 0, 0, 1, 0, 24'h0,  0);
        tbl[15] = mk(C_JAL, 12, 0, 0, 0, 0, 1, C_JAL,  31);

        reset = 1'b1;
        drive(24'h0, 0, 0, 0, 1'b1);
        m_ex  = '{default: '0};
        m_cnt = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ex_ctrl", ex_ctrl_o, 24'h0);
        chk("rst_ex_rs_data", ex_rs_data_o, 0);
        chk("rst_ex_pc4", ex_pc4_o, 0);
        chk("rst_ex_wr_reg", ex_wr_reg_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_flush", flush_ifid_o, 0);
        chk("rst_cnt", bubble_cnt_o, 0);
        reset = 1'b0;
        branch_taken_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].bt);
            #1;
            chk($sformatf("tbl%0d_stall", i), stall_o, tbl[i].exp_stall);
            chk($sformatf("tbl%0d_flush", i), flush_ifid_o, tbl[i].exp_flush);
            cycle_model();
            chk($sformatf("tbl%0d_ctrl", i), ex_ctrl_o, tbl[i].exp_ctrl);
            chk($sformatf("tbl%0d_wr", i), ex_wr_reg_o, tbl[i].exp_wr);
            if (i == 12) chk("jal_memtoreg", ex_ctrl_o[B_M2R +: 2], 2'b10);
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("tbl_cnt", bubble_cnt_o, 32'd4);
`else
        chk("tbl_cnt", bubble_cnt_o, 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            drive(ops[$urandom_range(0, 7)] | (24'($urandom_range(0, 15)) << B_ALUOP),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
            #1;
            cycle_model();
        end

        // reset lands between edges while a stall is pending
        drive(C_LW, 1, 8, 0, 1'b0);
        #1;
        cycle_model();
        drive(C_ADD, 8, 2, 3, 1'b0);
        #1;
        chk("pre_rst_stall", stall_o, 1);
        #2;
        reset = 1'b1;
        branch_taken_i = 1'b1;
        #1;
        m_ex  = '{default: '0};
        m_cnt = 32'd0;
        chk("mid_rst_stall", stall_o, 0);
        chk("mid_rst_flush", flush_ifid_o, 0);
        chk("mid_rst_ctrl", ex_ctrl_o, 24'h0);
        chk("mid_rst_wr", ex_wr_reg_o, 0);
        chk("mid_rst_rs_data", ex_rs_data_o, 0);
        chk("mid_rst_pc4", ex_pc4_o, 0);
        chk("mid_rst_cnt", bubble_cnt_o, 0);
        @(posedge clk);
        #1;
        chk("held_rst_ctrl", ex_ctrl_o, 24'h0);
        @(negedge clk);
        reset = 1'b0;
        branch_taken_i = 1'b0;
        #1;
        cycle_model();
        chk("post_rst_no_bubble", ex_ctrl_o, C_ADD);
        chk("post_rst_cnt", bubble_cnt_o, 0);

        // branch coinciding with a load-use: branch wins
        drive(C_LW, 1, 8, 0, 1'b0);
        #1;
        cycle_model();
        drive(C_ADD, 8, 2, 3, 1'b1);
        #1;
        chk("br_lu_stall", stall_o, 0);
        chk("br_lu_flush", flush_ifid_o, 1);
        cycle_model();
        chk("br_lu_bubble", ex_ctrl_o, 24'h0);
`ifdef ID_EX_PERF_CNT_EN
        chk("br_lu_cnt", bubble_cnt_o, 32'd1);

        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("preload_cnt", bubble_cnt_o, 32'hFFFF_FFFF);
        drive(C_BEQ, 0, 0, 0, 1'b1);
        #1;
        cycle_model();
        chk("wrap_cnt", bubble_cnt_o, 32'd0);
`else
        chk("br_lu_cnt", bubble_cnt_o, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
